normalize_16bit: RTL and testbench

Sequential 16-bit normalizer: the inverse partner of the team's 16-bit barrel shifter.
- Takes a 16-bit word and a direction, then finds the shift size that moves the leading one to bit 15 (left) or the trailing one to bit 0 (right).
- Returns the normalized word plus a 4-bit shift size in the same format the barrel shifter consumes.
- Feeding the result back into the barrel shifter with `shift`=`shift` output and `lr`=~`lr_o` restores the original word.
- Used ahead of the shifter in the datapath; start/valid/ack handshake, 4-stage binary search, one stage per clock.

---
 rtl/normalize_16bit.sv | 136 +++++++++++++
 tb/tb_normalize_16bit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/normalize_16bit.sv
// normalize_16bit: sequential leading/trailing-one normalizer, partner of the
// 16-bit barrel shifter. A 4-stage binary search (8,4,2,1) runs one stage per
// clock. Feeding out/shift into the barrel shifter with the opposite direction
// restores the captured input word.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   start  - request; taken in IDLE, or in DONE together with ack
//   lr     - 1 = normalize toward MSB, 0 = toward LSB; captured with start
//   in     - word to normalize; captured with start
//   ack    - consumer accepts the result while valid=1
//   busy   - search in progress (S8..S1)
//   valid  - result stable (DONE)
//   out    - normalized word (working register)
//   shift  - shift size applied, barrel-shifter format
//   lr_o   - captured direction
//   zero   - captured word was zero
module normalize_16bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        lr,
    input  logic [15:0] in,
    input  logic        ack,
    output logic        busy,
    output logic        valid,
    output logic [15:0] out,
    output logic [3:0]  shift,
    output logic        lr_o,
    output logic        zero
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S8   = 3'd1,
        S4   = 3'd2,
        S2   = 3'd3,
        S1   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] out_nx;
    logic [3:0]  shift_nx;
    logic        lr_nx;
    logic        zero_nx;

    // State and result registers; busy/valid are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
            out   <= 16'h0000;
            shift <= 4'h0;
            lr_o  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == S8) || (state_nx == S4) ||
                     (state_nx == S2) || (state_nx == S1);
            valid <= (state_nx == DONE);
            out   <= out_nx;
            shift <= shift_nx;
            lr_o  <= lr_nx;
            zero  <= zero_nx;
        end
    end

    // Next-state and working-register update
    always_comb begin
        state_nx = state;
        out_nx   = out;
        shift_nx = shift;
        lr_nx    = lr_o;
        zero_nx  = zero;

        case (state)
            IDLE: begin
                if (start) begin
                    out_nx   = in;
                    lr_nx    = lr;
                    shift_nx = 4'h0;
                    zero_nx  = (in == 16'h0000);
                    state_nx = S8;
                end
            end
            S8: begin
                if (lr_o ? (out[15:8] == 8'h00) : (out[7:0] == 8'h00)) begin
                    out_nx      = lr_o ? (out << 8) : (out >> 8);
                    shift_nx[3] = 1'b1;
                end
                state_nx = S4;
            end
            S4: begin
                if (lr_o ? (out[15:12] == 4'h0) : (out[3:0] == 4'h0)) begin
                    out_nx      = lr_o ? (out << 4) : (out >> 4);
                    shift_nx[2] = 1'b1;
                end
                state_nx = S2;
            end
            S2: begin
                if (lr_o ? (out[15:14] == 2'b00) : (out[1:0] == 2'b00)) begin
                    out_nx      = lr_o ? (out << 2) : (out >> 2);
                    shift_nx[1] = 1'b1;
                end
                state_nx = S1;
            end
            S1: begin
                if (lr_o ? !out[15] : !out[0]) begin
                    out_nx      = lr_o ? (out << 1) : (out >> 1);
                    shift_nx[0] = 1'b1;
                end
                state_nx = DONE;
            end
            DONE: begin
                // Result held until acknowledged; ack+start chains a new request
                if (ack) begin
                    if (start) begin
                        out_nx   = in;
                        lr_nx    = lr;
                        shift_nx = 4'h0;
                        zero_nx  = (in == 16'h0000);
                        state_nx = S8;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_normalize_16bit.sv
// tb_normalize_16bit: self-checking bench for normalize_16bit.
// Directed vector table, handshake/reset corner sequences, and random
// nonzero vectors checked against a barrel-shifter and zero-count model.
module tb_normalize_16bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        lr_w;
    logic [15:0] in_w;
    logic        ack;
    logic        busy;
    logic        valid;
    logic [15:0] out_w;
    logic [3:0]  shift;
    logic        lr_o;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    normalize_16bit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .lr    (lr_w),
        .in    (in_w),
        .ack   (ack),
        .busy  (busy),
        .valid (valid),
        .out   (out_w),
        .shift (shift),
        .lr_o  (lr_o),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] in;
        logic        lr;
        logic [15:0] exp_out;
        logic [3:0]  exp_shift;
        logic        exp_zero;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Logical barrel shifter model: lr=1 shifts left, lr=0 shifts right
    function automatic logic [15:0] barrel(input logic [15:0] x, input logic [3:0] s, input logic l);
        return l ? (x << s) : (x >> s);
    endfunction

    // Leading zeros (l=1) or trailing zeros (l=0) of a nonzero word
    function automatic logic [3:0] count_zeros(input logic [15:0] x, input logic l);
        int n = 0;
        for (int i = 0; i < 16; i++) begin
            if (x[l ? (15 - i) : i]) break;
            n++;
        end
        return 4'(n);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for valid after a capture edge; lat counts edges past the capture edge
    task automatic wait_done(output int lat, output int bcnt, output logic done);
        lat  = 0;
        bcnt = 0;
        done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (valid) begin
                done = 1'b1;
                lat  = i;
                break;
            end
            if (busy) bcnt++;
            step();
        end
    endtask

    task automatic do_op(input logic [15:0] a, input logic l,
                         output int lat, output int bcnt, output logic done);
        in_w  = a;
        lr_w  = l;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat, bcnt, done);
    endtask

    task automatic release_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy),  32'h0);
        check({tag, "_valid"}, 32'(valid), 32'h0);
        check({tag, "_out"},   32'(out_w), 32'h0);
        check({tag, "_shift"}, 32'(shift), 32'h0);
        check({tag, "_lr_o"},  32'(lr_o),  32'h0);
        check({tag, "_zero"},  32'(zero),  32'h0);
    endtask

    initial begin
        vec_t        vecs[11];
        int          lat;
        int          bcnt;
        logic        done;
        logic [15:0] a;
        logic        l;

        vecs[0]  = '{16'h0001, 1'b1, 16'h8000, 4'hF, 1'b0};
        vecs[1]  = '{16'h00A0, 1'b1, 16'hA000, 4'h8, 1'b0};
        vecs[2]  = '{16'h00A0, 1'b0, 16'h0005, 4'h5, 1'b0};
        vecs[3]  = '{16'h8000, 1'b1, 16'h8000, 4'h0, 1'b0};
        vecs[4]  = '{16'h0000, 1'b1, 16'h0000, 4'hF, 1'b1};
        vecs[5]  = '{16'h0000, 1'b0, 16'h0000, 4'hF, 1'b1};
        vecs[6]  = '{16'h0001, 1'b0, 16'h0001, 4'h0, 1'b0};
        vecs[7]  = '{16'h8000, 1'b0, 16'h0001, 4'hF, 1'b0};
        vecs[8]  = '{16'hFFFF, 1'b1, 16'hFFFF, 4'h0, 1'b0};
        vecs[9]  = '{16'h0300, 1'b1, 16'hC000, 4'h6, 1'b0};
        vecs[10] = '{16'h0300, 1'b0, 16'h0003, 4'h8, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        lr_w  = 1'b0;
        in_w  = 16'h0000;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        // Directed table: latency, busy length, result, handshake release
        foreach (vecs[i]) begin
            do_op(vecs[i].in, vecs[i].lr, lat, bcnt, done);
            check($sformatf("v%0d_done", i),  32'(done),     32'h1);
            check($sformatf("v%0d_lat", i),   32'(lat),      32'h4);
            check($sformatf("v%0d_busy", i),  32'(bcnt),     32'h4);
            check($sformatf("v%0d_out", i),   32'(out_w),    32'(vecs[i].exp_out));
            check($sformatf("v%0d_shift", i), 32'(shift),    32'(vecs[i].exp_shift));
            check($sformatf("v%0d_zero", i),  32'(zero),     32'(vecs[i].exp_zero));
            check($sformatf("v%0d_lr_o", i),  32'(lr_o),     32'(vecs[i].lr));
            release_ack();
            check($sformatf("v%0d_rel_valid", i), 32'(valid), 32'h0);
            check($sformatf("v%0d_rel_busy", i),  32'(busy),  32'h0);
        end

        // Hold ack low: result stable, start ignored
        do_op(16'h00A0, 1'b1, lat, bcnt, done);
        check("hold_done", 32'(done), 32'h1);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            in_w  = 16'h1234 + 16'(i);
            lr_w  = 1'b0;
            step();
            check($sformatf("hold%0d_valid", i), 32'(valid), 32'h1);
            check($sformatf("hold%0d_res", i), {11'h0, lr_o, shift, out_w}, {11'h0, 1'b1, 4'h8, 16'hA000});
        end
        // Back-to-back: ack with start captures immediately
        in_w  = 16'h0300;
        lr_w  = 1'b1;
        ack   = 1'b1;
        step();
        ack   = 1'b0;
        check("b2b_busy",  32'(busy),  32'h1);
        check("b2b_valid", 32'(valid), 32'h0);
        // Start pulse while busy must not disturb the result
        in_w  = 16'hFFFF;
        lr_w  = 1'b0;
        step();
        start = 1'b0;
        wait_done(lat, bcnt, done);
        check("b2b_done",  32'(done),  32'h1);
        check("b2b_lat",   32'(lat),   32'h3);
        check("b2b_out",   32'(out_w), 32'hC000);
        check("b2b_shift", 32'(shift), 32'h6);
        check("b2b_lr_o",  32'(lr_o),  32'h1);
        release_ack();
        check("b2b_rel_valid", 32'(valid), 32'h0);

        // Reset during S4 discards the operation
        in_w  = 16'h0001;
        lr_w  = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("mid_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        step();
        check_all_zero("midrst");
        reset = 1'b0;
        step();
        check("midrst_idle_valid", 32'(valid), 32'h0);
        check("midrst_idle_busy",  32'(busy),  32'h0);
        do_op(16'h0010, 1'b0, lat, bcnt, done);
        check("after_rst_done",  32'(done),  32'h1);
        check("after_rst_out",   32'(out_w), 32'h0001);
        check("after_rst_shift", 32'(shift), 32'h4);
        release_ack();

        // Random nonzero vectors against the barrel-shifter model
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom);
            if (a == 16'h0000) a = 16'h1234;
            l = 1'($urandom);
            do_op(a, l, lat, bcnt, done);
            check($sformatf("rnd%0d_done", n), 32'(done), 32'h1);
            if (done) begin
                check($sformatf("rnd%0d_shift in=%h lr=%b", n, a, l), 32'(shift), 32'(count_zeros(a, l)));
                check($sformatf("rnd%0d_fwd in=%h lr=%b", n, a, l), 32'(out_w), 32'(barrel(a, shift, l)));
                check($sformatf("rnd%0d_inv in=%h lr=%b", n, a, l), 32'(barrel(out_w, shift, ~lr_o)), 32'(a));
                check($sformatf("rnd%0d_zero", n), 32'(zero), 32'h0);
            end
            release_ack();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
